// File: rtl/agu_pkg.sv
// Shared mode/size codes and alignment masks for the AGU memory pipeline.
package agu_pkg;

  typedef enum logic [1:0] {
    MODE_RR      = 2'b00,
    MODE_BOFF    = 2'b01,
    MODE_POSTINC = 2'b10,
    MODE_RSVD    = 2'b11
  } agu_mode_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } agu_size_e;

  localparam logic [2:0] ALIGN_MASK_B = 3'b000;
  localparam logic [2:0] ALIGN_MASK_H = 3'b001;
  localparam logic [2:0] ALIGN_MASK_W = 3'b011;
  localparam logic [2:0] ALIGN_MASK_D = 3'b111;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [2:0] align_mask(agu_size_e size);
    logic [2:0] mask;
    mask = ALIGN_MASK_B;
    unique case (size)
      SZ_B: mask = ALIGN_MASK_B;
      SZ_H: mask = ALIGN_MASK_H;
      SZ_W: mask = ALIGN_MASK_W;
      SZ_D: mask = ALIGN_MASK_D;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/agu_pipe_reg.sv
// One valid/ready pipeline stage; the payload only loads on an accepted transfer so it
// holds steady while the downstream side stalls.
module agu_pipe_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        data_q <= in_data_i;
      end
    end
  end

endmodule

// File: rtl/agu_mem_pipe.sv
// Two-stage address generation unit: operand capture (S1) then add/sub and write-back (S2).
// Define AGU_ALIGN_CHECK_EN to enable the size-based misalignment flag.
module agu_mem_pipe
  import agu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned OFF_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dinA,
  input  logic [WIDTH-1:0] dinB,
  input  logic [OFF_W-1:0] OFFSET,
  input  logic [1:0]       OP_MEM,
  input  logic             ADD_SUB,
  input  logic [1:0]       SIZE,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             wb_en,
  output logic [WIDTH-1:0] wb_data,
  output logic             misalign
);

  localparam int unsigned S1W = 2 * WIDTH + 5;
  localparam int unsigned S2W = 2 * WIDTH + 2;

  // S1 payload layout: {a, op2, add_sub, mode, size}
  logic [WIDTH-1:0] off_ext;
  logic [WIDTH-1:0] op2_sel;
  logic [S1W-1:0]   s1_in;
  logic [S1W-1:0]   s1_out;
  logic             s1_valid;
  logic             s2_ready;

  assign off_ext = {{(WIDTH - OFF_W){OFFSET[OFF_W-1]}}, OFFSET};
  assign op2_sel = (agu_mode_e'(OP_MEM) == MODE_RR) ? dinB : off_ext;
  assign s1_in   = {dinA, op2_sel, ADD_SUB, OP_MEM, SIZE};

  agu_pipe_reg #(
    .Width(S1W)
  ) u_s1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (s1_in),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_ready),
    .out_data_o  (s1_out)
  );

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_op2;
  logic             s1_add_sub;
  agu_mode_e        s1_mode;
  agu_size_e        s1_size;

  assign s1_size    = agu_size_e'(s1_out[1:0]);
  assign s1_mode    = agu_mode_e'(s1_out[3:2]);
  assign s1_add_sub = s1_out[4];
  assign s1_op2     = s1_out[5 +: WIDTH];
  assign s1_a       = s1_out[WIDTH+5 +: WIDTH];

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dout_d;
  logic [WIDTH-1:0] wb_data_d;
  logic             wb_en_d;
  logic             mis_d;

  always_comb begin
    // Two's-complement subtraction, carry/borrow discarded.
    sum       = s1_add_sub ? (s1_a - s1_op2) : (s1_a + s1_op2);
    dout_d    = sum;
    wb_en_d   = 1'b0;
    wb_data_d = '0;
    if (s1_mode == MODE_POSTINC) begin
      dout_d    = s1_a;
      wb_en_d   = 1'b1;
      wb_data_d = sum;
    end
  end

`ifdef AGU_ALIGN_CHECK_EN
  assign mis_d = |(dout_d[2:0] & align_mask(s1_size));
`else
  logic unused_size;
  assign unused_size = ^s1_size;
  assign mis_d       = 1'b0;
`endif

  logic [S2W-1:0] s2_out;

  agu_pipe_reg #(
    .Width(S2W)
  ) u_s2 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_ready),
    .in_data_i   ({dout_d, wb_en_d, wb_data_d, mis_d}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (s2_out)
  );

  assign misalign = s2_out[0];
  assign wb_data  = s2_out[1 +: WIDTH];
  assign wb_en    = s2_out[WIDTH+1];
  assign dout     = s2_out[WIDTH+2 +: WIDTH];

endmodule

// File: tb/tb_agu_mem_pipe.sv
// Scoreboard bench for agu_mem_pipe: stimulus pushes expected results, a monitor pops them.
module tb_agu_mem_pipe;

  logic        clk_tb;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dinA;
  logic [63:0] dinB;
  logic [15:0] OFFSET;
  logic [1:0]  OP_MEM;
  logic        ADD_SUB;
  logic [1:0]  SIZE;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] dout;
  logic        wb_en;
  logic [63:0] wb_data;
  logic        misalign;

`ifdef AGU_ALIGN_CHECK_EN
  localparam bit AlignOn = 1'b1;
`else
  localparam bit AlignOn = 1'b0;
`endif

  typedef struct {
    logic [63:0] dout;
    logic        wb_en;
    logic [63:0] wb_data;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   n_pushed  = 0;
  int   n_popped  = 0;
  int   n_dropped = 0;

  agu_mem_pipe u_dut (
    .clk       (clk_tb),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dinA      (dinA),
    .dinB      (dinB),
    .OFFSET    (OFFSET),
    .OP_MEM    (OP_MEM),
    .ADD_SUB   (ADD_SUB),
    .SIZE      (SIZE),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .wb_en     (wb_en),
    .wb_data   (wb_data),
    .misalign  (misalign)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted output against the head of the scoreboard.
  always @(negedge clk_tb) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got dout 0x%0h, expected no output", dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_popped++;
        check("dout", dout, e.dout);
        check("wb_en", {63'd0, wb_en}, {63'd0, e.wb_en});
        check("wb_data", wb_data, e.wb_data);
        check("misalign", {63'd0, misalign}, {63'd0, e.mis});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the request is accepted.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [15:0] off,
                       input logic [1:0] op, input logic sub, input logic [1:0] sz,
                       input logic [63:0] e_dout, input logic e_wb, input logic [63:0] e_wbd,
                       input logic e_mis);
    int   n;
    exp_t e;
    n        = 0;
    dinA     = a;
    dinB     = b;
    OFFSET   = off;
    OP_MEM   = op;
    ADD_SUB  = sub;
    SIZE     = sz;
    in_valid = 1'b1;
    @(negedge clk_tb);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk_tb);
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got in_ready 0, expected 1 within 50 cycles");
    end else begin
      e.dout    = e_dout;
      e.wb_en   = e_wb;
      e.wb_data = e_wbd;
      e.mis     = e_mis & AlignOn;
      exp_q.push_back(e);
      n_pushed++;
    end
    @(posedge clk_tb);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk_tb);
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk_tb);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    dinA      = '0;
    dinB      = '0;
    OFFSET    = '0;
    OP_MEM    = 2'b00;
    ADD_SUB   = 1'b0;
    SIZE      = 2'b00;
    out_ready = 1'b1;

    repeat (2) @(posedge clk_tb);
    @(negedge clk_tb);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_dout", dout, 64'd0);
    check("rst_wb_en", {63'd0, wb_en}, 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_misalign", {63'd0, misalign}, 64'd0);
    @(posedge clk_tb);
    #1;
    rst = 1'b0;
    @(negedge clk_tb);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk_tb);
    #1;

    // Back-to-back basic modes
    issue(64'd20, 64'd10, 16'd0, 2'b00, 1'b0, 2'b00, 64'd30, 1'b0, 64'd0, 1'b0);
    issue(64'd20, 64'd10, 16'd0, 2'b00, 1'b1, 2'b00, 64'd10, 1'b0, 64'd0, 1'b0);
    issue(64'd100, 64'd777, 16'hFFFB, 2'b01, 1'b0, 2'b00, 64'd95, 1'b0, 64'd0, 1'b0);
    issue(64'h1000, 64'd0, 16'd8, 2'b10, 1'b0, 2'b00, 64'h1000, 1'b1, 64'h1008, 1'b0);
    issue(64'h100, 64'd5, 16'h10, 2'b10, 1'b1, 2'b00, 64'h100, 1'b1, 64'hF0, 1'b0);
    issue(64'd50, 64'd9, 16'd3, 2'b11, 1'b0, 2'b00, 64'd53, 1'b0, 64'd0, 1'b0);
    issue(64'd0, 64'd0, 16'd1, 2'b01, 1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 16'd1, 2'b01, 1'b0, 2'b00, 64'd0, 1'b0, 64'd0, 1'b0);
    issue(64'd7, 64'd0, 16'hFFFF, 2'b01, 1'b0, 2'b00, 64'd6, 1'b0, 64'd0, 1'b0);
    drain();

    // Backpressure: two accepts fill the pipe, then the rest wait for release
    out_ready = 1'b0;
    issue(64'd1, 64'd2, 16'd0, 2'b00, 1'b0, 2'b00, 64'd3, 1'b0, 64'd0, 1'b0);
    issue(64'd5, 64'd1, 16'd0, 2'b00, 1'b1, 2'b00, 64'd4, 1'b0, 64'd0, 1'b0);
    fork
      begin
        issue(64'h200, 64'd0, 16'h10, 2'b01, 1'b0, 2'b00, 64'h210, 1'b0, 64'd0, 1'b0);
        issue(64'h40, 64'd0, 16'hFFFC, 2'b10, 1'b0, 2'b00, 64'h40, 1'b1, 64'h3C, 1'b0);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk_tb);
          check("bp_in_ready", {63'd0, in_ready}, 64'd0);
          check("bp_out_valid", {63'd0, out_valid}, 64'd1);
          check("bp_hold_dout", dout, 64'd3);
        end
        @(posedge clk_tb);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two transactions in flight
    issue(64'd7, 64'd1, 16'd0, 2'b00, 1'b0, 2'b00, 64'd8, 1'b0, 64'd0, 1'b0);
    issue(64'd8, 64'd1, 16'd0, 2'b00, 1'b0, 2'b00, 64'd9, 1'b0, 64'd0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_dout", dout, 64'd0);
    n_dropped = n_dropped + exp_q.size();
    exp_q.delete();
    @(posedge clk_tb);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_tb);
      check("no_stale_output", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk_tb);
    #1;
    issue(64'd9, 64'd9, 16'd0, 2'b00, 1'b0, 2'b00, 64'd18, 1'b0, 64'd0, 1'b0);

    // Alignment flag
    issue(64'h1002, 64'd0, 16'd0, 2'b01, 1'b0, 2'b10, 64'h1002, 1'b0, 64'd0, 1'b1);
    issue(64'h1002, 64'd0, 16'd0, 2'b01, 1'b0, 2'b01, 64'h1002, 1'b0, 64'd0, 1'b0);
    issue(64'h1000, 64'd0, 16'd4, 2'b01, 1'b0, 2'b11, 64'h1004, 1'b0, 64'd0, 1'b1);
    issue(64'h1001, 64'd0, 16'd0, 2'b01, 1'b0, 2'b00, 64'h1001, 1'b0, 64'd0, 1'b0);
    issue(64'h1003, 64'd0, 16'd0, 2'b01, 1'b0, 2'b01, 64'h1003, 1'b0, 64'd0, 1'b1);
    drain();

    check("pushed_vs_popped", 64'(n_pushed), 64'(n_popped + n_dropped));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/agu_mem_pipe.md
Name: agu_mem_pipe

Overview:
- Parametrised, pipelined successor of the memory-operation address adder.
- Computes a memory address as A±B (register-register), A±OFFSET (base+offset) or A with post-increment write-back, under a valid/ready handshake on both sides.
- Sits between operand read and data-memory access in the processor datapath; backpressure from memory stalls it without losing transactions.

Parameters:
- WIDTH, 64: datapath, address and write-back width in bits.
- OFF_W, 16: OFFSET width in bits; OFFSET is signed and sign-extended to WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- dinA  in  WIDTH  base operand.
- dinB  in  WIDTH  index operand.
- OFFSET  in  OFF_W  signed immediate.
- OP_MEM  in  2  mode: 00 reg-reg, 01 base+offset, 10 post-increment, 11 reserved (treated as 01).
- ADD_SUB  in  1  0 = add, 1 = subtract.
- SIZE  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- dout  out  WIDTH  effective address.
- wb_en  out  1  base write-back required; set only in post-increment mode.
- wb_data  out  WIDTH  updated base value; 0 when wb_en = 0.
- misalign  out  1  address not aligned to SIZE.

Behaviour:
- Reset (async, active-high): both stage-valid flags clear. out_valid=0, dout=0, wb_en=0, wb_data=0, misalign=0. in_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation: in-flight transactions are dropped. There is no replay.
- Stage 1 (S1) registers:
  - dinA.
  - The selected second operand: dinB for mode 00, sign-extended OFFSET otherwise.
  - ADD_SUB, mode and SIZE.
- Stage 2 (S2) registers sum = A + (ADD_SUB ? ~op2 + 1 : op2), computed modulo 2^WIDTH with carry and borrow discarded.
  - Modes 00/01/11: dout = sum, wb_en=0, wb_data=0.
  - Mode 10: dout = A (unmodified base), wb_en=1, wb_data = sum.
- Latency: 2 cycles from accepted input to out_valid with no stall. Throughput is 1 per cycle.
- Handshake:
  - S2 advances when !out_valid || out_ready.
  - S1 advances into S2 under the same condition.
  - in_ready = !s1_valid || S2 advances. It is purely combinational on out_ready; there is no combinational path from in_valid.
  - While out_valid=1 && out_ready=0, dout/wb_en/wb_data/misalign hold stable.
- Full pipeline (both stages valid, out_ready=0): in_ready=0.
- Simultaneous drain of S2 and fill of S1 in the same cycle is allowed. No bubble is inserted.
- Sign extension: OFFSET=16'hFFFF → op2 = all ones (−1).
- Wrap-around: dinA=0, sub 1 → dout = 2^WIDTH−1. dinA=2^WIDTH−1, add 1 → dout = 0. No flag is raised.

Optional Feature:
- AGU_ALIGN_CHECK_EN:
  - Defined: misalign = 1 when the low bits of dout are nonzero for SIZE. Bits [0] for half, [1:0] for word, [2:0] for double; byte never misaligns. The flag is registered with S2 and valid only with out_valid. The transaction still completes.
  - Undefined: misalign tied 0 and SIZE is ignored. The port remains present.

Decomposition:
- Shared package agu_pkg holds:
  - mode codes MODE_RR=2'b00, MODE_BOFF=2'b01, MODE_POSTINC=2'b10.
  - size codes SZ_B/SZ_H/SZ_W/SZ_D.
  - per-size alignment mask constants.
- Sub-module agu_pipe_reg: one valid/ready pipeline register stage, parametrised on payload width. It is instantiated twice, once for S1 and once for S2.

Test Plan:
- Reg-reg add then sub: dinA=20, dinB=10, OP_MEM=00. ADD_SUB=0 → dout=30 two cycles later; ADD_SUB=1 → dout=10. wb_en=0 in both cases.
- Base+offset with negative immediate: dinA=100, OFFSET=16'hFFFB, OP_MEM=01, add → dout=95. Ignore dinB=777.
- Post-increment: dinA=0x1000, OFFSET=8, OP_MEM=10, add → dout=0x1000, wb_en=1, wb_data=0x1008.
- Backpressure: stream 4 back-to-back requests with out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepts.
  - dout holds the first result.
  - On release, all 4 results emerge in order with no loss or duplication.
- Wrap-around and reset:
  - dinA=0, sub OFFSET=1 → dout=64'hFFFF_FFFF_FFFF_FFFF.
  - Assert rst with 2 transactions in flight → out_valid=0 immediately; no stale output after release.
- With AGU_ALIGN_CHECK_EN: dinA=0x1002, SIZE=10 → misalign=1; SIZE=01 → misalign=0. Without the macro, misalign=0 for both.
